serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
Parameters:
REQ-001 SHALL provide parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
Ports:
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled on rising edge of clk.
REQ-005 SHALL have port A  input  WIDTH  minuend; captured on an accepted start.
REQ-006 SHALL have port B  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 SHALL have port bin  input  1  borrow-in; captured on an accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port diff  output  WIDTH  result A - B - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out; 1 when unsigned A < B + bin.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow of A - B - bin.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 Start acceptance: start=1 at an edge in IDLE or DONE SHALL capture A, B and bin, clear the bit counter, and move to RUN. Call that edge T.
REQ-015 Start in RUN SHALL be ignored. No state, operand or output change from that start.
REQ-016 RUN datapath: one bit per cycle, LSB first, through a single full-subtractor cell.
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - The borrow register is initialised from the captured bin.
REQ-017 Bit i (i = 0..WIDTH-1) SHALL be processed at edge T+1+i. Its d bit SHALL be shifted into the result shift register from the MSB side.
REQ-018 Completion: at edge T+WIDTH the FSM SHALL move to DONE and raise done.
  - Latency from start to done is exactly WIDTH cycles.
  - diff, bout and ovf SHALL be valid in the same cycle that done is high.
REQ-019 done SHALL be high for exactly one cycle.
  - DONE returns to IDLE at the next edge unless start=1 at that edge, in which case REQ-014 applies (back-to-back operation).
REQ-020 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-021 bout SHALL equal the final borrow register value after bit WIDTH-1.
REQ-022 ovf SHALL equal (A[MSB] ^ B[MSB]) & (A[MSB] ^ diff[MSB]), using the captured operands.
REQ-023 diff, bout and ovf SHALL hold their last completed values through IDLE. They SHALL update only at the completion edge.
  - During RUN they SHALL keep their previous results; the shift register is internal.
REQ-024 Operand inputs SHALL be don't-care except at the accepting edge. Changes during RUN SHALL NOT affect the result.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 rst=1 at an edge SHALL, in any state including mid-RUN:
  - force the FSM to IDLE;
  - clear busy, done, diff, bout and ovf to 0;
  - clear the borrow register, counter and shift register;
  - abandon any in-progress operation.
REQ-027 rst SHALL take priority over start at the same edge.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 A=0x35, B=0x12, bin=0, start pulsed → done high 8 cycles later; diff=0x23, bout=0, ovf=0; busy high for 8 cycles.
REQ-030 A=0x00, B=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
REQ-031 Signed overflow and borrow-in:
  - A=0x80, B=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
  - A=0x10, B=0x0F, bin=1 → diff=0x00, bout=0, ovf=0.
REQ-032 Start in RUN with new operands, plus back-to-back start:
  - A=0x35, B=0x12 running; start pulsed with A=0xFF, B=0x00 at cycle 3 of RUN → ignored; result diff=0x23 on schedule.
  - start=1 in the DONE cycle → new operation begins; done again 8 cycles later.
REQ-033 Reset during RUN, plus reset/start priority:
  - rst=1 at cycle 4 of RUN → next cycle busy=0, done=0, diff=0x00, bout=0, ovf=0; no done pulse follows.
  - rst and start both 1 at the same edge → FSM stays in IDLE.
REQ-034 Exhaustive/random check: all 65536 A/B pairs with bin=0 and bin=1 → diff, bout and ovf match a reference model computed as the 9-bit value {0,A} - {0,B} - bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin one bit per cycle (LSB first)
// through a single full-subtractor cell, reporting difference, borrow and signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic fs_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, busy_q, done_q;
  logic             bit_s, borrow_s, last_s;

  assign bit_s    = fs_diff(a_q[0], b_q[0], br_q);
  assign borrow_s = fs_borrow(a_q[0], b_q[0], br_q);
  assign last_s   = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath: operands shift right so bit 0 is always the current bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = A;
          b_d     = B;
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          sh_d    = {WIDTH{1'b0}};
          // Operand MSBs are kept aside because the shift registers lose them.
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d  = {1'b0, a_q[WIDTH-1:1]};
        b_d  = {1'b0, b_q[WIDTH-1:1]};
        br_d = borrow_s;
        sh_d = {bit_s, sh_q[WIDTH-1:1]};
        if (last_s) begin
          state_d = S_DONE;
          diff_d  = {bit_s, sh_q[WIDTH-1:1]};
          bout_d  = borrow_s;
          ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ bit_s);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sh_q    <= {WIDTH{1'b0}};
      br_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed scenarios plus a
// random back-to-back run, with expected results queued at each accepted start.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, bin;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, bout, ovf;
  logic [WIDTH-1:0] diff;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Packed as {bout, ovf, diff}.
  logic [9:0] sb[$];
  logic [9:0] hold_r;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] t;
    logic       ov;
    t  = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    ov = (a[7] ^ b[7]) & (a[7] ^ t[7]);
    return {t[8], ov, t[7:0]};
  endfunction

  // Called at a negedge: drives an accepted start for one cycle.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi);
    start = 1'b1;
    A     = a;
    B     = b;
    bin   = bi;
    sb.push_back(model(a, b, bi));
    @(negedge clk);
    start = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
    bin   = 1'($urandom);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL accept_busy: busy=%b expected 1", busy);
    else pass_cnt++;
  endtask

  // Walks the WIDTH run cycles; inj_k > 0 pulses a start with new operands mid-run.
  task automatic expect_done(input string name, input int inj_k);
    logic [9:0] exp;
    bit         run_ok;
    run_ok = 1'b1;
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      if (k == inj_k + 1 && inj_k > 0) start = 1'b0;
      if (k < WIDTH) begin
        if (busy !== 1'b1 || done !== 1'b0 || {bout, ovf, diff} !== hold_r) run_ok = 1'b0;
      end
      if (k == inj_k) begin
        start = 1'b1;
        A     = 8'hFF;
        B     = 8'h00;
        bin   = 1'b0;
      end
    end
    total_cnt++;
    if (!run_ok) $display("FAIL %s_run: busy/done/held outputs wrong during RUN (held %h)", name, hold_r);
    else pass_cnt++;
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_done: done=%b busy=%b expected done=1 busy=0 after %0d cycles", name, done, busy, WIDTH);
    else pass_cnt++;
    total_cnt++;
    if ({bout, ovf, diff} !== exp)
      $display("FAIL %s_result: {bout,ovf,diff}=%h expected %h", name, {bout, ovf, diff}, exp);
    else pass_cnt++;
    hold_r = exp;
  endtask

  task automatic test_idle_return(input string name);
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || {bout, ovf, diff} !== hold_r)
      $display("FAIL %s_idle: done=%b busy=%b res=%h expected 0 0 %h", name, done, busy, {bout, ovf, diff}, hold_r);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_r = 10'h000;
    total_cnt++;
    if ({busy, done, bout, ovf, diff} !== 12'h000)
      $display("FAIL reset: busy=%b done=%b bout=%b ovf=%b diff=%h expected all 0", busy, done, bout, ovf, diff);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    issue(8'h35, 8'h12, 1'b0); expect_done("basic", 0);    test_idle_return("basic");
    issue(8'h00, 8'h01, 1'b0); expect_done("borrow", 0);   test_idle_return("borrow");
    issue(8'h80, 8'h01, 1'b0); expect_done("overflow", 0); test_idle_return("overflow");
    issue(8'h10, 8'h0F, 1'b1); expect_done("bin", 0);      test_idle_return("bin");
  endtask

  task automatic test_start_in_run;
    issue(8'h35, 8'h12, 1'b0);
    expect_done("start_in_run", 3);
  endtask

  // Entered at the DONE negedge of the previous operation.
  task automatic test_back_to_back;
    issue(8'h7F, 8'h80, 1'b1);
    expect_done("back_to_back", 0);
    test_idle_return("back_to_back");
  endtask

  task automatic test_reset_mid_run;
    bit quiet;
    issue(8'h35, 8'h12, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    hold_r = 10'h000;
    total_cnt++;
    if ({busy, done, bout, ovf, diff} !== 12'h000)
      $display("FAIL rst_mid_run: busy=%b done=%b bout=%b ovf=%b diff=%h expected all 0", busy, done, bout, ovf, diff);
    else pass_cnt++;
    quiet = 1'b1;
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total_cnt++;
    if (!quiet) $display("FAIL rst_abandon: done/busy rose after reset, expected 0");
    else pass_cnt++;
  endtask

  task automatic test_rst_start_priority;
    rst = 1'b1; start = 1'b1; A = 8'h35; B = 8'h12; bin = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_priority: busy=%b done=%b expected 0 0", busy, done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_priority_hold: busy=%b done=%b expected 0 0", busy, done);
    else pass_cnt++;
    issue(8'h10, 8'h0F, 1'b1); expect_done("first_after_rst", 0); test_idle_return("first_after_rst");
  endtask

  task automatic test_random;
    logic [7:0] ta[6] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic [7:0] tb[6] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h00};
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], 1'(i));
      expect_done("corner", 0);
    end
    for (int n = 0; n < 1500; n++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      expect_done("random", 0);
    end
    test_idle_return("random");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_in_run;
    test_back_to_back;
    test_reset_mid_run;
    test_rst_start_priority;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
